// File: rtl/prbs8_pkg.sv
// Shared definitions for the 8-bit PRBS generator/checker pair
// (polynomial x^8+x^6+x^5+x^4+1, left shift, feedback into the LSB).
package prbs8_pkg;

  localparam logic [7:0] TAP_MASK     = 8'hB8;
  localparam logic [7:0] DEFAULT_SEED = 8'h01;

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    VERIFY = 2'd1,
    LOCKED = 2'd2
  } state_t;

  function automatic logic [7:0] prbs8_next(input logic [7:0] x);
    return {x[6:0], ^(x & TAP_MASK)};
  endfunction

endpackage

// File: rtl/prbs8_checker_if.sv
// Word stream into the PRBS checker plus its lock/error status outputs.
// Handshake: din is sampled on a rising clk edge only when enb is high; there
// is no ready, the checker accepts a word every cycle, clr is a level command.
interface prbs8_checker_if #(
  parameter int CNT_W = 16
);
  logic             enb;
  logic [7:0]       din;
  logic             clr;
  logic             locked;
  logic             err;
  logic [CNT_W-1:0] err_cnt;
  logic [CNT_W-1:0] bit_err_cnt;

  modport master (
    output enb, din, clr,
    input  locked, err, err_cnt, bit_err_cnt
  );

  modport slave (
    input  enb, din, clr,
    output locked, err, err_cnt, bit_err_cnt
  );
endinterface

// File: rtl/prbs8_checker_popcount8.sv
// Combinational population count of an 8-bit word.
module popcount8 (
  input  logic [7:0] x,
  output logic [3:0] cnt
);
  always_comb begin
    cnt = '0;
    for (int i = 0; i < 8; i++) begin
      cnt = cnt + {3'b000, x[i]};
    end
  end
endmodule

// File: rtl/prbs8_checker.sv
// Self-synchronising PRBS8 checker: seeds from the stream, verifies LOCK_CNT
// matches, then flywheels its own predictor and counts word/bit errors.
module prbs8_checker
  import prbs8_pkg::*;
#(
  parameter int LOCK_CNT = 4,
  parameter int LOSS_CNT = 3,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  prbs8_checker_if.slave   bus,
  output state_t           state_dbg
);
  localparam int RW = $clog2(LOCK_CNT + 1);
  localparam int MW = $clog2(LOSS_CNT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t         st;
  logic [7:0]     exp;
  logic [RW-1:0]  run_cnt;
  logic [MW-1:0]  miss_cnt;
  logic [3:0]     pc;
  logic [CNT_W:0] bit_sum;

  popcount8 u_pop (
    .x   (bus.din ^ exp),
    .cnt (pc)
  );

  // One extra bit catches the carry so an overflowing add clamps to max.
  assign bit_sum   = {1'b0, bus.bit_err_cnt} + (CNT_W+1)'(pc);
  assign state_dbg = st;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st              <= SEARCH;
      exp             <= '0;
      run_cnt         <= '0;
      miss_cnt        <= '0;
      bus.locked      <= 1'b0;
      bus.err         <= 1'b0;
      bus.err_cnt     <= '0;
      bus.bit_err_cnt <= '0;
    end else begin
      bus.err <= 1'b0;
      if (bus.enb) begin
        case (st)
          SEARCH: begin
            if (bus.din != 8'h00) begin
              exp     <= prbs8_next(bus.din);
              run_cnt <= '0;
              st      <= VERIFY;
            end
          end
          VERIFY: begin
            if (bus.din == 8'h00) begin
              st <= SEARCH;
            end else if (bus.din == exp) begin
              exp     <= prbs8_next(bus.din);
              run_cnt <= run_cnt + 1'b1;
              if (run_cnt == RW'(LOCK_CNT - 1)) begin
                st         <= LOCKED;
                miss_cnt   <= '0;
                bus.locked <= 1'b1;
              end
            end else begin
              exp     <= prbs8_next(bus.din);
              run_cnt <= '0;
            end
          end
          LOCKED: begin
            // Flywheel: the prediction advances from itself, never from din.
            exp <= prbs8_next(exp);
            if (bus.din == exp) begin
              miss_cnt <= '0;
            end else begin
              bus.err <= 1'b1;
              if (bus.err_cnt != CNT_MAX) bus.err_cnt <= bus.err_cnt + 1'b1;
              bus.bit_err_cnt <= bit_sum[CNT_W] ? CNT_MAX : bit_sum[CNT_W-1:0];
              if (miss_cnt == MW'(LOSS_CNT - 1)) begin
                st         <= SEARCH;
                run_cnt    <= '0;
                miss_cnt   <= '0;
                bus.locked <= 1'b0;
              end else begin
                miss_cnt <= miss_cnt + 1'b1;
              end
            end
          end
          default: st <= SEARCH;
        endcase
      end
      // Placed last so a same-cycle clear overrides any error increment.
      if (bus.clr) begin
        bus.err_cnt     <= '0;
        bus.bit_err_cnt <= '0;
      end
    end
  end
endmodule

// File: tb/tb_prbs8_checker.sv
// Bench for prbs8_checker: a 16-bit and a 4-bit counter instance share one
// stimulus stream and are compared against a word-level reference model.
module tb_prbs8_checker;
  import prbs8_pkg::*;

  localparam int LOCK_N = 4;
  localparam int LOSS_N = 3;

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst_n;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  prbs8_checker_if #(.CNT_W(16)) bus_a ();
  prbs8_checker_if #(.CNT_W(4))  bus_b ();
  state_t st_a, st_b;

  prbs8_checker #(.LOCK_CNT(LOCK_N), .LOSS_CNT(LOSS_N), .CNT_W(16)) dut_a (
    .clk(clk), .rst_n(rst_n), .bus(bus_a), .state_dbg(st_a)
  );
  prbs8_checker #(.LOCK_CNT(LOCK_N), .LOSS_CNT(LOSS_N), .CNT_W(4)) dut_b (
    .clk(clk), .rst_n(rst_n), .bus(bus_b), .state_dbg(st_b)
  );

  // ---------------- scoreboard / reference model ----------------
  int n_vec  = 0;
  int n_miss = 0;

  // Model mode: 0 hunting for a seed, 1 counting matches, 2 flywheeling.
  int m_mode, m_exp, m_run, m_miss, m_err;
  int m_ecnt [2];
  int m_bcnt [2];
  int cmax   [2] = '{65535, 15};
  int gen;  // reference generator state

  task automatic check(input string tag, input int obs, input int req);
    n_vec++;
    if (obs !== req) begin
      n_miss++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, req, $time);
    end
  endtask

  function automatic int nxt(input int x);
    int fb;
    fb = ((x >> 7) ^ (x >> 5) ^ (x >> 4) ^ (x >> 3)) & 1;
    return ((x * 2) % 256) + fb;
  endfunction

  function automatic int ones(input int x);
    int n = 0;
    for (int i = 0; i < 8; i++) n += (x >> i) & 1;
    return n;
  endfunction

  task automatic model_reset();
    m_mode = 0; m_exp = 0; m_run = 0; m_miss = 0; m_err = 0;
    for (int k = 0; k < 2; k++) begin m_ecnt[k] = 0; m_bcnt[k] = 0; end
  endtask

  task automatic model_step(input int e, input int d, input int c);
    m_err = 0;
    if (e != 0) begin
      if (m_mode == 0) begin
        if (d != 0) begin m_exp = nxt(d); m_run = 0; m_mode = 1; end
      end else if (m_mode == 1) begin
        if (d == 0) m_mode = 0;
        else if (d == m_exp) begin
          m_exp = nxt(d);
          m_run++;
          if (m_run == LOCK_N) begin m_mode = 2; m_miss = 0; end
        end else begin
          m_exp = nxt(d); m_run = 0;
        end
      end else begin
        if (d != m_exp) begin
          m_err = 1;
          for (int k = 0; k < 2; k++) begin
            m_ecnt[k] = (m_ecnt[k] + 1 > cmax[k]) ? cmax[k] : m_ecnt[k] + 1;
            m_bcnt[k] = (m_bcnt[k] + ones(d ^ m_exp) > cmax[k]) ? cmax[k]
                        : m_bcnt[k] + ones(d ^ m_exp);
          end
          m_miss++;
          if (m_miss == LOSS_N) begin m_mode = 0; m_run = 0; m_miss = 0; end
        end else begin
          m_miss = 0;
        end
        m_exp = nxt(m_exp);
      end
    end
    if (c != 0) for (int k = 0; k < 2; k++) begin m_ecnt[k] = 0; m_bcnt[k] = 0; end
  endtask

  task automatic check_all(input string tag);
    check({tag, "_locked_a"}, int'(bus_a.locked), (m_mode == 2) ? 1 : 0);
    check({tag, "_locked_b"}, int'(bus_b.locked), (m_mode == 2) ? 1 : 0);
    check({tag, "_err_a"},    int'(bus_a.err), m_err);
    check({tag, "_err_b"},    int'(bus_b.err), m_err);
    check({tag, "_state_a"},  int'(st_a), m_mode);
    check({tag, "_state_b"},  int'(st_b), m_mode);
    check({tag, "_ecnt_a"},   int'(bus_a.err_cnt), m_ecnt[0]);
    check({tag, "_bcnt_a"},   int'(bus_a.bit_err_cnt), m_bcnt[0]);
    check({tag, "_ecnt_b"},   int'(bus_b.err_cnt), m_ecnt[1]);
    check({tag, "_bcnt_b"},   int'(bus_b.bit_err_cnt), m_bcnt[1]);
  endtask

  // ---------------- driver ----------------
  // Called right after a falling edge; drives, clocks, then checks at the next fall.
  task automatic apply(input string tag, input int e, input int d, input int c);
    bus_a.enb = e[0]; bus_a.din = d[7:0]; bus_a.clr = c[0];
    bus_b.enb = e[0]; bus_b.din = d[7:0]; bus_b.clr = c[0];
    @(posedge clk);
    model_step(e, d, c);
    @(negedge clk);
    check_all(tag);
  endtask

  task automatic send_gen(input string tag);
    apply(tag, 1, gen, 0);
    gen = nxt(gen);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // ---------------- test sequence ----------------
  initial begin
    rst_n = 1'b0;
    bus_a.enb = 1'b0; bus_a.din = 8'h00; bus_a.clr = 1'b0;
    bus_b.enb = 1'b0; bus_b.din = 8'h00; bus_b.clr = 1'b0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    check_all("reset");
    rst_n = 1'b1;

    // Acquisition: 01 seeds, 02 04 08 11 match, locked the cycle after 11.
    gen = int'(DEFAULT_SEED);
    for (int i = 0; i < 4; i++) begin
      send_gen("acq");
      check("acq_not_yet", int'(bus_a.locked), 0);
    end
    send_gen("acq");
    check("acq_locked", int'(bus_a.locked), 1);
    check("acq_next_exp", gen, 8'h23);

    // Single corruption: 26 in place of 23.
    apply("corrupt", 1, 8'h26, 0);
    gen = nxt(gen);
    check("corrupt_err", int'(bus_a.err), 1);
    send_gen("corrupt");
    check("corrupt_noerr", int'(bus_a.err), 0);
    send_gen("corrupt");
    check("corrupt_ecnt", int'(bus_a.err_cnt), 1);
    check("corrupt_bcnt", int'(bus_a.bit_err_cnt), 2);
    check("corrupt_locked", int'(bus_a.locked), 1);

    // Loss and reacquire.
    apply("clr", 0, 8'h00, 1);
    apply("loss", 1, 8'hAA, 0);
    apply("loss", 1, 8'h55, 0);
    apply("loss", 1, 8'hAA, 0);
    check("loss_unlocked", int'(bus_a.locked), 0);
    check("loss_ecnt", int'(bus_a.err_cnt), 3);
    gen = int'(DEFAULT_SEED);
    for (int i = 0; i < 5; i++) send_gen("reacq");
    check("reacq_locked", int'(bus_a.locked), 1);

    // Zero stream, then acquisition with enb gaps and junk on din while idle.
    do_reset();
    for (int i = 0; i < 20; i++) apply("zero", 1, 0, 0);
    check("zero_search", int'(st_a), 0);
    gen = int'(DEFAULT_SEED);
    for (int i = 0; i < 5; i++) begin
      send_gen("gap");
      apply("gap_idle", 0, int'($urandom_range(0, 255)), 0);
    end
    check("gap_locked", int'(bus_a.locked), 1);

    // Saturation: inverted word then correct word, 20 pairs.
    for (int i = 0; i < 20; i++) begin
      apply("sat", 1, (~gen) & 8'hFF, 0);
      gen = nxt(gen);
      send_gen("sat");
    end
    check("sat_ecnt_b", int'(bus_b.err_cnt), 15);
    check("sat_bcnt_b", int'(bus_b.bit_err_cnt), 15);
    check("sat_locked", int'(bus_b.locked), 1);
    // clr collides with an error: counters clear, pulse still seen.
    apply("sat_clr", 1, (~gen) & 8'hFF, 1);
    gen = nxt(gen);
    check("sat_clr_ecnt", int'(bus_b.err_cnt), 0);
    check("sat_clr_err", int'(bus_b.err), 1);

    // Asynchronous reset between edges while locked.
    send_gen("pre_rst");
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check("async_locked", int'(bus_a.locked), 0);
    check("async_ecnt", int'(bus_a.err_cnt), 0);
    check("async_bcnt", int'(bus_a.bit_err_cnt), 0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    gen = int'(DEFAULT_SEED);
    for (int i = 0; i < 5; i++) send_gen("post_rst");
    check("post_rst_locked", int'(bus_a.locked), 1);

    // Randomized stream: corruption, zeros, reseeds, gaps and clears.
    for (int i = 0; i < 600; i++) begin
      int e, c, r, d;
      e = ($urandom_range(0, 3) != 0) ? 1 : 0;
      c = ($urandom_range(0, 31) == 0) ? 1 : 0;
      r = int'($urandom_range(0, 99));
      if (r < 4) gen = int'($urandom_range(1, 255));
      if (r >= 4 && r < 12) d = int'($urandom_range(0, 255));
      else if (r >= 12 && r < 15) d = 0;
      else d = gen;
      apply("rand", e, d, c);
      if (e != 0) gen = nxt(gen);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
